// File: rtl/policy_deck_shuffler.sv
// policy_deck_shuffler: in-place Fisher-Yates shuffle of the policy-card bit list.
// Build option: define SHUFFLE_STATS_EN to enable the reject_cnt statistics counter.
module policy_deck_shuffler #(
    parameter int DECK_W    = 18,
    parameter int RETRY_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DECK_W-1:0] deck_in,
    input  logic [4:0]        count_in,
    input  logic [7:0]        rnd,
    output logic [DECK_W-1:0] deck_out,
    output logic [4:0]        count_out,
    output logic              busy,
    output logic              done,
    output logic [7:0]        reject_cnt
);

    typedef enum logic {IDLE = 1'b0, STEP = 1'b1} state_t;

    localparam logic [4:0]        DECK_N     = 5'(DECK_W);
    localparam logic [7:0]        RETRY_LAST = 8'(RETRY_MAX - 1);
    localparam logic [DECK_W-1:0] ONE_W      = {{(DECK_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [DECK_W-1:0] deck_q, deck_d;
    logic [4:0]        count_q, count_d;
    logic [4:0]        i_q, i_d;
    logic [7:0]        retry_q, retry_d;
    logic              done_q, done_d;

    logic [4:0]        n;
    logic [DECK_W-1:0] keep;
    logic [4:0]        mask;
    logic [4:0]        cand;
    logic              accept;
    logic              fits;
    logic              at_limit;
    logic              advance;
    logic              unused_rnd_hi;

    assign unused_rnd_hi = ^rnd[7:5];

    // Handshake: start is taken only in IDLE outside the done cycle; done is a
    // one-cycle pulse and deck_out/count_out hold until the next taken start.
    always_comb begin
        n        = (count_in > DECK_N) ? DECK_N : count_in;
        keep     = (ONE_W << n) - ONE_W;
        mask     = i_q | (i_q >> 1) | (i_q >> 2) | (i_q >> 3) | (i_q >> 4);
        cand     = rnd[4:0] & mask;
        fits     = (cand <= i_q);
        at_limit = (retry_q == RETRY_LAST);
        advance  = fits || at_limit;
        accept   = start && !done_q && (state_q == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (n > 5'd1)) state_d = STEP;
            STEP:    if (advance && (i_q == 5'd1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == STEP);
    end

    always_comb begin
        deck_d  = deck_q;
        count_d = count_q;
        i_d     = i_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        if (accept) begin
            deck_d  = deck_in & keep;
            count_d = n;
            retry_d = 8'd0;
            if (n <= 5'd1) done_d = 1'b1;
            else           i_d    = n - 5'd1;
        end else if (state_q == STEP) begin
            if (fits) begin
                deck_d[i_q]  = deck_q[cand];
                deck_d[cand] = deck_q[i_q];
                retry_d      = 8'd0;
            end else if (at_limit) begin
                // Forced step: behaves as j = i, so the deck is left untouched.
                retry_d = 8'd0;
            end else begin
                retry_d = retry_q + 8'd1;
            end
            if (advance) begin
                if (i_q == 5'd1) done_d = 1'b1;
                else             i_d    = i_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deck_q  <= '0;
            count_q <= 5'd0;
            i_q     <= 5'd0;
            retry_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            deck_q  <= deck_d;
            count_q <= count_d;
            i_q     <= i_d;
            retry_q <= retry_d;
            done_q  <= done_d;
        end
    end

`ifdef SHUFFLE_STATS_EN
    logic [7:0] rej_q, rej_d;

    // Counts rejected and forced cycles alike, saturating at 255.
    always_comb begin
        rej_d = rej_q;
        if (accept) rej_d = 8'd0;
        else if ((state_q == STEP) && !fits && (rej_q != 8'hFF)) rej_d = rej_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rej_q <= 8'd0;
        else     rej_q <= rej_d;
    end

    assign reject_cnt = rej_q;
`else
    assign reject_cnt = 8'd0;
`endif

    assign deck_out  = deck_q;
    assign count_out = count_q;
    assign done      = done_q;

endmodule
